// File: rtl/best_arr_sender.sv
`default_nettype none
// ============================================================================
// Module      : best_arr_sender
// Description : Streams best indices then split best distances from the
//               result SRAMs to the host pad FIFO in blocked pixel order.
// Revision    : 1.0 - initial release
// ============================================================================
module best_arr_sender #(
    parameter  int DATA_WIDTH = 11,
    parameter  int ROW_SIZE   = 32,
    parameter  int COL_SIZE   = 16,
    parameter  int BLOCKING   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    localparam int AW         = $clog2(NUM_QUERYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send_best_arr,
    output logic                    send_done,
    output logic                    busy,
    output logic                    idx_rd_en,
    output logic [AW-1:0]           idx_rd_addr,
    input  logic [DATA_WIDTH-1:0]   idx_rd_data,
    output logic                    dist_rd_en,
    output logic [AW-1:0]           dist_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] dist_rd_data,
    input  logic                    out_fifo_deq,
    output logic [DATA_WIDTH-1:0]   out_fifo_rdata,
    output logic                    out_fifo_rempty_n
);

    localparam int XN   = ROW_SIZE / 2 / BLOCKING;
    localparam int XI_W = $clog2(BLOCKING + 1);
    localparam int X_W  = $clog2(XN + 1);
    localparam int Y_W  = $clog2(COL_SIZE + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = CW + 2;

    typedef enum logic [1:0] {S_IDLE, S_IDX, S_DIST, S_DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_px;
    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic [XI_W-1:0]         r_xi;
    logic                    r_idx_vld, r_dist_vld, r_hi_vld;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]           r_count;

    logic                    w_xi_last, w_y_last, w_x_last, w_last;
    logic [AW-1:0]           w_addr;
    logic [SW-1:0]           w_used;
    logic                    w_idx_ok, w_dist_ok, w_issue, w_idle_pipe;
    logic                    w_enq, w_deq;
    logic [DATA_WIDTH-1:0]   w_enq_data;

    assign w_xi_last = (r_xi == XI_W'(BLOCKING - 1));
    assign w_y_last  = (r_y  == Y_W'(COL_SIZE - 1));
    assign w_x_last  = (r_x  == X_W'(XN - 1));
    assign w_last    = r_px && w_x_last && w_y_last && w_xi_last;

    assign w_addr = AW'(r_px) * AW'(ROW_SIZE / 2) + AW'(r_y) * AW'(ROW_SIZE)
                  + AW'(r_x) * AW'(BLOCKING) + AW'(r_xi);
    assign idx_rd_addr  = w_addr;
    assign dist_rd_addr = w_addr;

    // Words already owed to the FIFO: returning read data plus the held upper half.
    assign w_used    = SW'(r_count) + SW'(r_idx_vld) + SW'({r_dist_vld, 1'b0}) + SW'(r_hi_vld);
    assign w_idx_ok  = (w_used + SW'(1)) <= SW'(FIFO_DEPTH);
    // Back-to-back dist reads would collide with the upper-half enqueue slot.
    assign w_dist_ok = ((w_used + SW'(2)) <= SW'(FIFO_DEPTH)) && !r_dist_vld;
    assign w_idle_pipe = (r_count == '0) && !r_idx_vld && !r_dist_vld && !r_hi_vld;
    assign w_issue   = idx_rd_en || dist_rd_en;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        idx_rd_en   = 1'b0;
        dist_rd_en  = 1'b0;
        send_done   = 1'b0;
        case (r_state)
            S_IDLE:  if (send_best_arr) w_state_nxt = S_IDX;
            S_IDX: begin
                idx_rd_en = w_idx_ok;
                if (w_idx_ok && w_last) w_state_nxt = S_DIST;
            end
            S_DIST: begin
                dist_rd_en = w_dist_ok;
                if (w_dist_ok && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_idle_pipe) begin
                    send_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            idx_rd_en  = 1'b0;
            dist_rd_en = 1'b0;
            send_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_px       <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_xi       <= '0;
            r_idx_vld  <= 1'b0;
            r_dist_vld <= 1'b0;
            r_hi_vld   <= 1'b0;
            r_hi       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx_vld  <= idx_rd_en;
            r_dist_vld <= dist_rd_en;
            r_hi_vld   <= r_dist_vld;
            if (r_dist_vld) r_hi <= dist_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
            if (w_issue) begin
                r_xi <= w_xi_last ? '0 : r_xi + XI_W'(1);
                if (w_xi_last) begin
                    r_y <= w_y_last ? '0 : r_y + Y_W'(1);
                    if (w_y_last) begin
                        r_x <= w_x_last ? '0 : r_x + X_W'(1);
                        if (w_x_last) r_px <= ~r_px;
                    end
                end
            end
        end
    end

    assign w_enq      = r_idx_vld || r_dist_vld || r_hi_vld;
    assign w_enq_data = r_idx_vld  ? idx_rd_data :
                        r_dist_vld ? dist_rd_data[DATA_WIDTH-1:0] : r_hi;
    assign w_deq      = out_fifo_deq && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= w_enq_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_fifo_rdata    = r_mem[r_rd_ptr];
    assign out_fifo_rempty_n = (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_best_arr_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_best_arr_sender
// Description : Scoreboard bench for best_arr_sender with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_best_arr_sender;

    localparam int DW     = 11;
    localparam int NQ     = 512;
    localparam int AW     = 9;
    localparam int TOTAL  = 1536;
    localparam int BUDGET = 20000;

    logic              clk = 1'b0;
    logic              rst, send_best_arr, send_done, busy;
    logic              idx_rd_en, dist_rd_en, out_fifo_deq, out_fifo_rempty_n;
    logic [AW-1:0]     idx_rd_addr, dist_rd_addr;
    logic [DW-1:0]     idx_rd_data, out_fifo_rdata;
    logic [2*DW-1:0]   dist_rd_data;

    logic [DW-1:0]     idx_mem  [NQ];
    logic [2*DW-1:0]   dist_mem [NQ];
    logic [DW-1:0]     sb [$];
    logic [DW-1:0]     got [TOTAL];
    int                n_checks = 0;
    int                n_fail   = 0;

    best_arr_sender dut (
        .clk               (clk),
        .rst               (rst),
        .send_best_arr     (send_best_arr),
        .send_done         (send_done),
        .busy              (busy),
        .idx_rd_en         (idx_rd_en),
        .idx_rd_addr       (idx_rd_addr),
        .idx_rd_data       (idx_rd_data),
        .dist_rd_en        (dist_rd_en),
        .dist_rd_addr      (dist_rd_addr),
        .dist_rd_data      (dist_rd_data),
        .out_fifo_deq      (out_fifo_deq),
        .out_fifo_rdata    (out_fifo_rdata),
        .out_fifo_rempty_n (out_fifo_rempty_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (idx_rd_en)  idx_rd_data  <= idx_mem[idx_rd_addr];
        if (dist_rd_en) dist_rd_data <= dist_mem[dist_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Blocked scan order: px, x, y, xi from outer to inner.
    task automatic push_expected();
        int a;
        logic [2*DW-1:0] d;
        for (int ph = 0; ph < 2; ph++)
            for (int px = 0; px < 2; px++)
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 16; y++)
                        for (int xi = 0; xi < 4; xi++) begin
                            a = px * 16 + y * 32 + x * 4 + xi;
                            if (ph == 0) begin
                                sb.push_back(DW'(a));
                            end else begin
                                d = 22'(a * 3 + 2048);
                                sb.push_back(d[DW-1:0]);
                                sb.push_back(d[2*DW-1:DW]);
                            end
                        end
    endtask

    task automatic run(input int period, input int stall_at, input int rst_at,
                       input int repulse_at, input bit lat, input string name);
        int  pops = 0, cyc = 0, dones = 0, stall_cnt = 0, rst_dones = 0;
        bit  want, rden_seen = 1'b0, repulsed = 1'b0, aborted = 1'b0;
        logic [DW-1:0] exp_w;
        @(negedge clk);
        send_best_arr = 1'b1;
        push_expected();
        @(negedge clk);
        send_best_arr = 1'b0;
        while (cyc < BUDGET) begin
            if (dones > 0 && !busy) break;
            if (lat && cyc == 0) begin
                chk({name, "_lat_rden"}, 32'(idx_rd_en), 1);
                chk({name, "_lat_addr"}, 32'(idx_rd_addr), 0);
                chk({name, "_lat_busy"}, 32'(busy), 1);
                chk({name, "_lat_empty0"}, 32'(out_fifo_rempty_n), 0);
            end
            if (lat && cyc == 1) chk({name, "_lat_empty1"}, 32'(out_fifo_rempty_n), 0);
            if (lat && cyc == 2) chk({name, "_lat_ready"}, 32'(out_fifo_rempty_n), 1);
            if (send_done) begin
                dones++;
                chk({name, "_done_at_end"}, pops, TOTAL);
            end
            if (pops == rst_at) begin
                rst = 1'b1;
                out_fifo_deq = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk({name, "_rst_empty"}, 32'(out_fifo_rempty_n), 0);
                chk({name, "_rst_busy"}, 32'(busy), 0);
                for (int k = 0; k < 6; k++) begin
                    if (send_done) rst_dones++;
                    @(negedge clk);
                end
                chk({name, "_rst_no_done"}, rst_dones, 0);
                sb.delete();
                aborted = 1'b1;
                break;
            end
            send_best_arr = (pops == repulse_at) && !repulsed;
            if (send_best_arr) repulsed = 1'b1;
            if (pops == stall_at && stall_cnt < 100) begin
                want = 1'b0;
                stall_cnt++;
                if (stall_cnt > 10 && (idx_rd_en || dist_rd_en)) rden_seen = 1'b1;
                if (stall_cnt == 100) begin
                    chk({name, "_stall_full"}, 32'(out_fifo_rempty_n), 1);
                    chk({name, "_stall_rden"}, 32'(rden_seen), 0);
                end
            end else begin
                want = (cyc % period) == 0;
            end
            out_fifo_deq = want;
            if (want && out_fifo_rempty_n) begin
                if (sb.size() == 0) begin
                    chk({name, "_extra_word"}, sb.size(), 1);
                end else begin
                    exp_w = sb.pop_front();
                    chk($sformatf("%s_word%0d", name, pops), 32'(out_fifo_rdata), 32'(exp_w));
                end
                if (pops < TOTAL) got[pops] = out_fifo_rdata;
                pops++;
            end
            cyc++;
            @(negedge clk);
        end
        out_fifo_deq  = 1'b0;
        send_best_arr = 1'b0;
        if (cyc >= BUDGET) chk({name, "_timeout"}, cyc, 0);
        if (!aborted) begin
            chk({name, "_total"}, pops, TOTAL);
            chk({name, "_dones"}, dones, 1);
            chk({name, "_sb_left"}, sb.size(), 0);
            chk({name, "_idle"}, 32'(busy), 0);
        end
    endtask

    int spot_idx [11] = '{0, 1, 2, 3, 4, 64, 256, 512, 513, 514, 515};
    int spot_exp [11] = '{0, 1, 2, 3, 32, 4, 16, 0, 1, 3, 1};

    initial begin
        for (int a = 0; a < NQ; a++) begin
            idx_mem[a]  = DW'(a);
            dist_mem[a] = 22'(a * 3 + 2048);
        end
        rst = 1'b1;
        send_best_arr = 1'b0;
        out_fifo_deq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_empty",  32'(out_fifo_rempty_n), 0);
        chk("rst_rdata",  32'(out_fifo_rdata), 0);
        chk("rst_idx_en", 32'(idx_rd_en), 0);
        chk("rst_dst_en", 32'(dist_rd_en), 0);
        chk("rst_done",   32'(send_done), 0);
        chk("rst_addr",   32'(idx_rd_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        run(3, -1, -1, -1, 1'b1, "t1");
        for (int i = 0; i < 11; i++)
            chk($sformatf("spot_word%0d", spot_idx[i]), 32'(got[spot_idx[i]]), spot_exp[i]);

        run(1, 600, -1, -1, 1'b0, "t3");
        run(1, -1, -1, -1, 1'b0, "t4");
        run(2, -1, 700, -1, 1'b0, "t5");
        run(2, -1, -1, -1, 1'b0, "t5r");
        run(1, -1, -1, 300, 1'b0, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
